// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_L,
        CNT_H,
        DATA,
        WRITE,
        CHECK,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         HDR_LEN      = 3;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs incoming bytes little-endian into a 32-bit word, one lane per accepted byte.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data,
    output logic        word_full,
    output logic [31:0] word_next
);

    logic [1:0]  byte_idx;
    logic [31:0] lanes;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            byte_idx <= 2'd0;
        end else if (load) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Lane contents need no reset: every lane is overwritten before a word is used.
    always_ff @(posedge clk) begin
        if (load) begin
            lanes <= word_next;
        end
    end

    always_comb begin
        word_next = lanes;
        word_next[{byte_idx, 3'b000} +: 8] = data;
    end

    assign word_full = load && (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader driving the instruction-memory write port.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         WIDTH = 32,
    parameter int         DEPTH = 128,
    parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [$clog2(DEPTH*4)-1:0] wr_addr0,
    output logic [WIDTH-1:0]          wr_din0,
    output logic                      we0,
    output logic                      cpu_hold,
    output logic                      done,
    output logic                      err
);

    localparam int AW = $clog2(DEPTH * 4);
    localparam int IW = $clog2(DEPTH) + 1;

    state_t        state, next;
    logic [15:0]   cnt;
    logic [15:0]   cnt_full;
    logic [IW-1:0] word_idx;
    logic [7:0]    chk;
    logic          accept, is_sync, load, clear, word_full, last_word;
    logic [31:0]   word_next;

    assign accept    = in_valid && in_ready;
    assign is_sync   = accept && (state == IDLE) && (in_data == SYNC);
    assign load      = accept && (state == DATA);
    assign clear     = is_sync;
    assign cnt_full  = {in_data, cnt[7:0]};
    assign last_word = (16'(word_idx) + 16'd1) == cnt;

    assign in_ready = (state != WRITE) && (state != ERR);
    assign we0      = (state == WRITE);

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .data      (in_data),
        .word_full (word_full),
        .word_next (word_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:  if (is_sync) next = CNT_L;
            CNT_L: if (accept) next = CNT_H;
            CNT_H: begin
                if (accept) begin
                    if (cnt_full > 16'(DEPTH))   next = ERR;
                    else if (cnt_full == 16'd0)  next = CHECK;
                    else                         next = DATA;
                end
            end
            DATA:  if (word_full) next = WRITE;
            WRITE: next = last_word ? CHECK : DATA;
            CHECK: if (accept) next = (in_data == chk) ? IDLE : ERR;
            ERR:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Frame bookkeeping; reinitialised on every SYNC, so no reset is needed.
    always_ff @(posedge clk) begin
        if (is_sync) begin
            chk      <= 8'd0;
            word_idx <= '0;
        end
        if (accept && state == CNT_L) cnt[7:0]  <= in_data;
        if (accept && state == CNT_H) cnt[15:8] <= in_data;
        if (load)                     chk       <= chk ^ in_data;
        if (state == WRITE)           word_idx  <= word_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_addr0 <= '0;
            wr_din0  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (is_sync) begin
                cpu_hold <= 1'b1;
                err      <= 1'b0;
            end
            if (word_full) begin
                wr_addr0 <= {word_idx[AW-3:0], 2'b00};
                wr_din0  <= word_next;
            end
            if (next == ERR && state != ERR) begin
                err <= 1'b1;
            end
            if (accept && state == CHECK && in_data == chk) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard and immediate-assertion checks.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  wr_addr0;
    logic [31:0] wr_din0;
    logic        we0, cpu_hold, done, err;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    logic [8:0] last_addr = 9'd0;
    bit bp = 1'b0;

    logic [40:0] exp_q[$];
    logic [31:0] words[0:DEPTH-1];

    imem_loader #(.WIDTH(32), .DEPTH(DEPTH), .SYNC(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_addr0 (wr_addr0),
        .wr_din0  (wr_din0),
        .we0      (we0),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) done_cnt++;
        if (rst && we0) begin
            wr_cnt++;
            last_addr = wr_addr0;
            check("in_ready_in_write", 64'(in_ready), 64'd0);
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write: got addr=%0h data=%0h want none", wr_addr0, wr_din0);
            end
            if (exp_q.size() != 0) begin
                logic [40:0] e;
                e = exp_q.pop_front();
                check("write", 64'({wr_addr0, wr_din0}), 64'(e));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        @(negedge clk);
        if (bp) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_data = b;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            total++;
            bad++;
            $error("FAIL in_ready_timeout: got=0 want=1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_words(input int first, input int n, inout logic [7:0] c);
        logic [31:0] w;
        for (int i = first; i < first + n; i++) begin
            exp_q.push_back({9'(i * 4), words[i]});
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                c = c ^ w[8*k +: 8];
                send_byte(w[8*k +: 8]);
            end
        end
    endtask

    task automatic send_frame(input int n, input bit bad_chk);
        logic [7:0] c;
        logic [15:0] n16;
        int d0;
        c = 8'd0;
        n16 = 16'(n);
        d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        send_words(0, n, c);
        send_byte(bad_chk ? ~c : c);
        @(negedge clk);
        check("frame_done", 64'(done), 64'(!bad_chk));
        check("frame_err", 64'(err), 64'(bad_chk));
        check("frame_hold", 64'(cpu_hold), 64'(bad_chk));
        @(negedge clk);
        check("done_pulse_end", 64'(done), 64'd0);
        check("done_count", 64'(done_cnt - d0), 64'(!bad_chk));
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_we0", 64'(we0), 64'd0);
        check("rst_addr", 64'(wr_addr0), 64'd0);
        check("rst_din", 64'(wr_din0), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        logic [7:0] c;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        rst = 1'b1;

        // Nominal two-word load; checksum 0x80.
        words[0] = 32'h0000_0013;
        words[1] = 32'h0020_00B3;
        w0 = wr_cnt;
        send_frame(2, 1'b0);
        check("nominal_writes", 64'(wr_cnt - w0), 64'd2);
        check("nominal_addr", 64'(last_addr), 64'h004);

        // Leading garbage is discarded without starting a frame.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        @(negedge clk);
        check("garbage_hold", 64'(cpu_hold), 64'd0);
        words[0] = $urandom;
        w0 = wr_cnt;
        send_frame(1, 1'b0);
        check("garbage_writes", 64'(wr_cnt - w0), 64'd1);

        // Bad checksum leaves err set and the core held; the next good frame recovers.
        words[0] = 32'hA5A5_1234;
        send_frame(1, 1'b1);
        @(negedge clk);
        check("badchk_err_sticky", 64'(err), 64'd1);
        check("badchk_hold_sticky", 64'(cpu_hold), 64'd1);
        words[0] = 32'hCAFE_F00D;
        send_frame(1, 1'b0);

        // Oversize count: error the cycle after CNT_H, no writes.
        w0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h81);
        send_byte(8'h00);
        @(negedge clk);
        check("oversize_err", 64'(err), 64'd1);
        check("oversize_in_err_state", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("oversize_idle", 64'(in_ready), 64'd1);
        check("oversize_err_sticky", 64'(err), 64'd1);
        check("oversize_writes", 64'(wr_cnt - w0), 64'd0);

        // Full-depth frame reaches the last word address.
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        w0 = wr_cnt;
        send_frame(DEPTH, 1'b0);
        check("full_writes", 64'(wr_cnt - w0), 64'(DEPTH));
        check("full_last_addr", 64'(last_addr), 64'h1FC);

        // Zero-count frame: only SYNC, count and a zero checksum.
        w0 = wr_cnt;
        send_frame(0, 1'b0);
        check("zero_writes", 64'(wr_cnt - w0), 64'd0);

        // Random valid gaps, then a reset mid-frame after the 6th data byte.
        bp = 1'b1;
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        send_frame(3, 1'b0);
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        c = 8'd0;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        send_words(0, 1, c);
        send_byte(words[1][7:0]);
        send_byte(words[1][15:8]);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        send_frame(2, 1'b0);
        bp = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
